// File: rtl/addersub_pkg.sv
// Shared types and constants for the adder-subtractor checker.
package addersub_pkg;

  localparam int NUM_VECTORS = 8;
  localparam int IDX_W       = $clog2(NUM_VECTORS);
  localparam int ERR_W       = 4;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    FINISH
  } state_e;

  // Packed so that {m, a, b} maps directly onto the vector index bits.
  typedef struct packed {
    logic m;
    logic a;
    logic b;
  } vec_t;

  function automatic vec_t idx_to_vec(input logic [IDX_W-1:0] idx);
    return vec_t'(idx);
  endfunction

endpackage

// File: rtl/addersub_checker_if.sv
// Bus between the checker and the 1-bit adder-subtractor under test.
interface addersub_checker_if;
  logic dut_a;
  logic dut_b;
  logic dut_m;
  logic dut_c;
  logic dut_s;

  // The checker drives operands and mode, and reads back carry and sum.
  modport master (output dut_a, dut_b, dut_m, input dut_c, dut_s);
  modport slave  (input dut_a, dut_b, dut_m, output dut_c, dut_s);
endinterface

// File: rtl/addersub_model.sv
// Reference 1-bit adder-subtractor: the result the checker expects.
module addersub_model (
  input  logic a,
  input  logic b,
  input  logic m,
  output logic c_exp,
  output logic s_exp
);

  // The sum bit is the same for both modes. Subtract is a + ~b + 1,
  // whose carry-out reduces to a | ~b.
  always_comb begin
    s_exp = a ^ b;
    c_exp = m ? (a | ~b) : (a & b);
  end

endmodule

// File: rtl/addersub_checker.sv
// Exhaustive checker for a 1-bit adder-subtractor. It drives each of the
// 8 {m,a,b} vectors, waits for the result to settle, then compares it.
module addersub_checker
  import addersub_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  addersub_checker_if.master        dut,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ERR_W-1:0]          err_count,
  output logic [NUM_VECTORS-1:0]    fail_vec
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = ERR_W'(NUM_VECTORS);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q;
  logic [3:0]             settle_q;
  vec_t                   vec_q;
  logic                   pass_q;
  logic [ERR_W-1:0]       err_q;
  logic [NUM_VECTORS-1:0] fail_q;
  logic                   c_exp, s_exp;
  logic                   mismatch;

  addersub_model u_model (
    .a     (vec_q.a),
    .b     (vec_q.b),
    .m     (vec_q.m),
    .c_exp (c_exp),
    .s_exp (s_exp)
  );

  assign mismatch = (dut.dut_c != c_exp) || (dut.dut_s != s_exp);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start is only honoured in IDLE, so it is ignored
  // mid-pass and on the done cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   state_d = SETTLE;
      SETTLE:  if (settle_q == SETTLE_LAST) state_d = CHECK;
      CHECK:   state_d = (idx_q == LAST_IDX) ? FINISH : DRIVE;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == FINISH);
  end

  // Datapath: vector register, settle counter, and the result accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q    <= '0;
      settle_q <= '0;
      vec_q    <= '0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fail_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q  <= '0;
            err_q  <= '0;
            fail_q <= '0;
            pass_q <= 1'b0;
          end
        end
        DRIVE: begin
          vec_q    <= idx_to_vec(idx_q);
          settle_q <= '0;
        end
        SETTLE: settle_q <= settle_q + 4'd1;
        CHECK: begin
          if (mismatch) begin
            if (err_q != ERR_MAX) err_q <= err_q + 1'b1;
            fail_q[idx_q] <= 1'b1;
          end
          if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
        end
        FINISH:  pass_q <= (err_q == '0);
        default: ;
      endcase
    end
  end

  assign dut.dut_a = vec_q.a;
  assign dut.dut_b = vec_q.b;
  assign dut.dut_m = vec_q.m;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_addersub_checker.sv
// Bench for addersub_checker: behavioural adder-subtractor with optional
// faults, directed passes with hand-computed results.
module tb_addersub_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       start0, start1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [3:0] err0, err1;
  logic [7:0] fv0, fv1;
  int         fault;      // 0 golden, 1 carry stuck at 0, 2 sum inverted
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  addersub_checker_if bus0 ();
  addersub_checker_if bus1 ();

  // Full adder on (a, b^m, cin=m): a true adder-subtractor cell.
  function automatic logic ref_c(input logic a, input logic b, input logic m);
    logic bb;
    bb = b ^ m;
    return (a & bb) | (m & (a ^ bb));
  endfunction

  function automatic logic ref_s(input logic a, input logic b, input logic m);
    return a ^ (b ^ m) ^ m;
  endfunction

  assign bus0.dut_c = (fault == 1) ? 1'b0 : ref_c(bus0.dut_a, bus0.dut_b, bus0.dut_m);
  assign bus0.dut_s = ref_s(bus0.dut_a, bus0.dut_b, bus0.dut_m) ^ (fault == 2);
  assign bus1.dut_c = ref_c(bus1.dut_a, bus1.dut_b, bus1.dut_m);
  assign bus1.dut_s = ref_s(bus1.dut_a, bus1.dut_b, bus1.dut_m);

  addersub_checker u_dut0 (
    .clk (clk), .reset (reset), .start (start0), .dut (bus0),
    .busy (busy0), .done (done0), .pass (pass0),
    .err_count (err0), .fail_vec (fv0)
  );

  addersub_checker #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk (clk), .reset (reset), .start (start1), .dut (bus1),
    .busy (busy1), .done (done1), .pass (pass1),
    .err_count (err1), .fail_vec (fv1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start in cycle 0 and count cycles until done. Optionally re-pulse
  // start at cycle restart_at, and always hold start during the done cycle.
  task automatic run_pass(input int sel, input int restart_at, output int lat);
    bit got;
    got = 0;
    lat = 0;
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    while (!got && lat < 200) begin
      tick();
      lat++;
      start0 = 1'b0;
      start1 = 1'b0;
      if (lat == restart_at) begin
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      end
      if ((sel == 0) ? done0 : done1) got = 1;
    end
    if (!got) begin
      chk("done_timeout", 0, 1);
      lat = -1;
    end
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    chk("done_one_cycle",    int'((sel == 0) ? done0 : done1), 0);
    chk("start_at_done_ign", int'((sel == 0) ? busy0 : busy1), 0);
  endtask

  initial begin
    int lat;
    int n_done;
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    fault  = 0;
    tick();
    tick();
    chk("rst_busy",  int'(busy0), 0);
    chk("rst_done",  int'(done0), 0);
    chk("rst_pass",  int'(pass0), 0);
    chk("rst_err",   int'(err0), 0);
    chk("rst_fv",    int'(fv0), 0);
    chk("rst_vec",   int'({bus0.dut_m, bus0.dut_a, bus0.dut_b}), 0);
    reset = 1'b0;
    tick();

    // Golden pass at SETTLE_CYCLES=2: 8*(2+2)+1 cycles.
    run_pass(0, 0, lat);
    chk("gold_latency", lat, 33);
    chk("gold_pass", int'(pass0), 1);
    chk("gold_err",  int'(err0), 0);
    chk("gold_fv",   int'(fv0), 0);
    chk("gold_vec_retained", int'({bus0.dut_m, bus0.dut_a, bus0.dut_b}), 7);

    // Start re-pulsed mid-pass must not restart it.
    run_pass(0, 10, lat);
    chk("restart_latency", lat, 33);
    chk("restart_pass", int'(pass0), 1);

    // Reset together with start at cycle 20 aborts the pass.
    start0 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      start0 = 1'b0;
    end
    chk("abort_busy_before", int'(busy0), 1);
    reset  = 1'b1;
    start0 = 1'b1;
    tick();
    reset  = 1'b0;
    start0 = 1'b0;
    chk("abort_busy", int'(busy0), 0);
    chk("abort_done", int'(done0), 0);
    chk("abort_pass", int'(pass0), 0);
    chk("abort_err",  int'(err0), 0);
    chk("abort_fv",   int'(fv0), 0);
    chk("abort_vec",  int'({bus0.dut_m, bus0.dut_a, bus0.dut_b}), 0);
    n_done = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done0) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    chk("abort_idle", int'(busy0), 0);

    // Carry stuck at 0: expected carry is 1 for vectors 3,4,6,7.
    fault = 1;
    run_pass(0, 0, lat);
    chk("stuckc_latency", lat, 33);
    chk("stuckc_pass", int'(pass0), 0);
    chk("stuckc_err",  int'(err0), 4);
    chk("stuckc_fv",   int'(fv0), 8'hD8);

    // Sum inverted: every vector mismatches.
    fault = 2;
    run_pass(0, 0, lat);
    chk("invs_pass", int'(pass0), 0);
    chk("invs_err",  int'(err0), 8);
    chk("invs_fv",   int'(fv0), 8'hFF);

    // Next start clears the previous failing result.
    fault = 0;
    run_pass(0, 0, lat);
    chk("reclear_pass", int'(pass0), 1);
    chk("reclear_fv",   int'(fv0), 0);

    // SETTLE_CYCLES=1: 8*(1+2)+1 cycles.
    run_pass(1, 0, lat);
    chk("s1_latency", lat, 25);
    chk("s1_pass", int'(pass1), 1);
    chk("s1_err",  int'(err1), 0);
    chk("s1_fv",   int'(fv1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
